// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared glyph constants and digit index type for the BCD display scanner
package bcd_disp_pkg;
   localparam logic [6:0] GLYPH_0    = 7'h3F;
   localparam logic [6:0] GLYPH_1    = 7'h06;
   localparam logic [6:0] GLYPH_2    = 7'h5B;
   localparam logic [6:0] GLYPH_3    = 7'h4F;
   localparam logic [6:0] GLYPH_4    = 7'h66;
   localparam logic [6:0] GLYPH_5    = 7'h6D;
   localparam logic [6:0] GLYPH_6    = 7'h7D;
   localparam logic [6:0] GLYPH_7    = 7'h07;
   localparam logic [6:0] GLYPH_8    = 7'h7F;
   localparam logic [6:0] GLYPH_9    = 7'h6F;
   localparam logic [6:0] GLYPH_DASH = 7'h40;
   localparam logic [6:0] GLYPH_OFF  = 7'h00;
   typedef logic [1:0] dig_t;
   localparam dig_t DIG_UNITS = 2'd0;
   localparam dig_t DIG_TENS  = 2'd1;
   localparam dig_t DIG_HUNDS = 2'd2;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-high gfedcba glyph, dash for non-decimal nibbles
module seg7_decode
   import bcd_disp_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] glyph_o
);
   // table lookup; A-F fall through to the dash glyph
   always_comb begin
      glyph_o = GLYPH_DASH;
      case (nibble_i)
         4'd0: glyph_o = GLYPH_0;
         4'd1: glyph_o = GLYPH_1;
         4'd2: glyph_o = GLYPH_2;
         4'd3: glyph_o = GLYPH_3;
         4'd4: glyph_o = GLYPH_4;
         4'd5: glyph_o = GLYPH_5;
         4'd6: glyph_o = GLYPH_6;
         4'd7: glyph_o = GLYPH_7;
         4'd8: glyph_o = GLYPH_8;
         4'd9: glyph_o = GLYPH_9;
         default: glyph_o = GLYPH_DASH;
      endcase
   end
endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: 3-digit multiplexed 7-segment scanner with blank gaps, frame snapshot and leading-zero blanking
module bcd_seg_scan
   import bcd_disp_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int BLANK_CYC      = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] bcd,
   input  logic        lzb_en,
   output logic [2:0]  an,
   output logic [6:0]  seg
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
   localparam logic [2:0] AN_POL  = {3{AN_ACTIVE_LOW}};
   localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};

   logic [CW-1:0] cnt_q, cnt_d;
   dig_t          idx_q, idx_d;
   logic [11:0]   shadow_bcd_q, shadow_bcd_d;
   logic          shadow_lzb_q, shadow_lzb_d;
   logic [2:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    nib;
   logic [6:0]    glyph;
   logic          wrap, snap, hund_zero, tens_zero, blanked, lit;

   seg7_decode u_dec (
      .nibble_i (nib),
      .glyph_o  (glyph)
   );

   // slot counter, digit sequencing, frame snapshot and registered output selection
   always_comb begin
      wrap         = cnt_q == CNT_LAST;
      cnt_d        = wrap ? '0 : cnt_q + CW'(1);
      idx_d        = wrap ? (idx_q == DIG_HUNDS ? DIG_UNITS : idx_q + 2'd1) : idx_q;
      snap         = idx_q == DIG_UNITS && cnt_q == '0;
      shadow_bcd_d = snap ? bcd : shadow_bcd_q;
      shadow_lzb_d = snap ? lzb_en : shadow_lzb_q;
      nib          = idx_q == DIG_HUNDS ? shadow_bcd_q[11:8] :
                     idx_q == DIG_TENS  ? shadow_bcd_q[7:4]  : shadow_bcd_q[3:0];
      hund_zero    = shadow_bcd_q[11:8] == 4'd0;
      tens_zero    = shadow_bcd_q[7:4] == 4'd0;
      blanked      = shadow_lzb_q && ((idx_q == DIG_HUNDS && hund_zero) ||
                                      (idx_q == DIG_TENS && hund_zero && tens_zero));
      lit          = cnt_q >= BLANK_END && !blanked;
      an_d         = (lit ? 3'b001 << idx_q : 3'b000) ^ AN_POL;
      seg_d        = (lit ? glyph : GLYPH_OFF) ^ SEG_POL;
   end

   // state and output registers; reset forces every digit and segment off at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= DIG_UNITS;
         shadow_bcd_q <= '0;
         shadow_lzb_q <= 1'b0;
         an_q         <= AN_POL;
         seg_q        <= GLYPH_OFF ^ SEG_POL;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_bcd_q <= shadow_bcd_d;
         shadow_lzb_q <= shadow_lzb_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
endmodule
